// File: rtl/aes_pkg.sv
// Shared AES layout definitions: widths, beat states and the ShiftRows
// packing functions used by both the stream receiver and its bench.
package aes_pkg;

  localparam int STATE_W = 128;
  localparam int WORD_W  = 32;

  // Beat position within a four-word block.
  typedef enum logic [1:0] {
    W0 = 2'd0,
    W1 = 2'd1,
    W2 = 2'd2,
    W3 = 2'd3
  } beat_e;

  function automatic logic [WORD_W-1:0] rotl8(input logic [WORD_W-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [WORD_W-1:0] rotr8(input logic [WORD_W-1:0] w);
    return {w[7:0], w[31:8]};
  endfunction

  function automatic logic [WORD_W-1:0] rotr16(input logic [WORD_W-1:0] w);
    return {w[15:0], w[31:16]};
  endfunction

  // x layout: [31:0]=row0 ... [127:96]=row3; the packed word leads with row0.
  function automatic logic [STATE_W-1:0] shiftrows_f(input logic [STATE_W-1:0] x);
    return {x[31:0], rotl8(x[63:32]), rotr16(x[95:64]), rotr8(x[127:96])};
  endfunction

  // Exact inverse of shiftrows_f.
  function automatic logic [STATE_W-1:0] inv_shiftrows_f(input logic [STATE_W-1:0] y);
    return {rotl8(y[31:0]), rotr16(y[63:32]), rotr8(y[95:64]), y[127:96]};
  endfunction

endpackage

// File: rtl/state_fifo.sv
// Small synchronous FIFO holding restored AES states. Storage is cleared on
// reset so the head reads as zero while empty.
module state_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next-state for storage, pointers and occupancy; pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Register update with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  a_no_pop_empty : assert property (@(posedge clk) disable iff (!rst_n)
    !(pop_i && count_q == '0));
  a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !pop_i && count_q == CNT_W'(DEPTH)));

endmodule

// File: rtl/inv_shiftrows_rx.sv
// Word-serial inverse ShiftRows receiver: assembles four beats, restores the
// pre-ShiftRows state and queues it for a 128-bit valid/ready consumer.
//
// state | meaning
// ------+-----------------------------------------------
// W0    | waiting for beat 0 (packed y[127:96])
// W1    | waiting for beat 1 (packed y[95:64])
// W2    | waiting for beat 2 (packed y[63:32])
// W3    | waiting for beat 3 (y[31:0]); must carry s_last
module inv_shiftrows_rx
  import aes_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WORD_W-1:0]  s_data,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [STATE_W-1:0] m_data,
  output logic               frame_err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  beat_e                 cnt_q, cnt_d;
  logic [3*WORD_W-1:0]   asm_q, asm_d;
  logic                  frame_err_q, frame_err_d;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [CNT_W-1:0]      fifo_count;
  logic [STATE_W-1:0]    result;

  // Only beat 3 can ever be refused, and only from registered occupancy.
  assign s_ready   = (cnt_q != W3) || (fifo_count < DEPTH_C);
  assign accept    = s_valid && s_ready;
  assign result    = inv_shiftrows_f({asm_q, s_data});
  assign m_valid   = (fifo_count != '0);
  assign pop       = m_valid && m_ready;
  assign frame_err = frame_err_q;

  // Beat sequencing, assembly and framing checks.
  always_comb begin
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    if (accept) begin
      case (cnt_q)
        W0: begin
          asm_d[95:64] = s_data;
          cnt_d        = s_last ? W0 : W1;
          frame_err_d  = s_last;
        end
        W1: begin
          asm_d[63:32] = s_data;
          cnt_d        = s_last ? W0 : W2;
          frame_err_d  = s_last;
        end
        W2: begin
          asm_d[31:0]  = s_data;
          cnt_d        = s_last ? W0 : W3;
          frame_err_d  = s_last;
        end
        W3: begin
          cnt_d        = W0;
          push         = s_last;
          frame_err_d  = !s_last;
        end
        default: cnt_d = W0;
      endcase
    end
  end

  // State, assembly and error-pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= W0;
      asm_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      frame_err_q <= frame_err_d;
    end
  end

  state_fifo #(
    .WIDTH (STATE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (result),
    .pop_i   (pop),
    .dout_o  (m_data),
    .count_o (fifo_count)
  );

endmodule

// File: doc/inv_shiftrows_rx.md
# inv_shiftrows_rx

Word-serial receiver that takes a 128-bit AES state packed in `shiftrows` output format, delivered as four 32-bit beats, and restores the pre-ShiftRows state. It reassembles the beats, applies the exact inverse of `shiftrows`, and buffers results in a small FIFO for a 128-bit valid/ready consumer. It is the stream-side counterpart of `shiftrows`, used on the verification and loopback path of the AES-256-CTR datapath.

## Interface
- `FIFO_DEPTH`, default 2: output buffer entries; must be a power of two and at least 2.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `s_valid`  in  1  input beat valid.
- `s_ready`  out  1  input beat accepted when `s_valid && s_ready`.
- `s_data`  in  32  input word.
- `s_last`  in  1  marks the final beat of a block; legal only on beat 3.
- `m_valid`  out  1  FIFO head valid.
- `m_ready`  in  1  consumer accepts the head when `m_valid && m_ready`.
- `m_data`  out  128  restored state, in `shiftrows` input layout (`[31:0]`=row0 … `[127:96]`=row3).
- `frame_err`  out  1  one-cycle pulse when a framing error is detected.

## Operation
- Beat counter `cnt` (2 bits) is the FSM, with states W0→W1→W2→W3→W0. It advances only on an accepted beat.
- Beat k fills the packed word y: W0→y[127:96], W1→y[95:64], W2→y[63:32], W3→y[31:0]. Beats W0–W2 go to a 96-bit assembly register. Beat W3 is used directly.
- Inverse transform, with all rotates on 32 bits:
  - row0 = y[127:96]
  - row1 = rotr8(y[95:64])
  - row2 = rotr16(y[63:32])
  - row3 = rotl8(y[31:0])
  - result = {row3, row2, row1, row0}
  - Required property: inverse(shiftrows(x)) == x for all x.
- Accepted W3 beat with `s_last`=1: push the result into the FIFO, then cnt→W0.
- Accepted beat in W0–W2 with `s_last`=1: discard the partial block, cnt→W0, pulse `frame_err` next cycle.
- Accepted W3 beat with `s_last`=0: discard the block, no push, cnt→W0, pulse `frame_err` next cycle.
- `s_ready` = (cnt != W3) || (fifo_count < FIFO_DEPTH).
  - Registered-state only: no combinational path from `m_ready`.
  - Beats W0–W2 are always accepted, even when the FIFO is full.
- FIFO rules:
  - `m_valid` = (fifo_count != 0); `m_data` = head entry.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Pop when empty and push when full cannot occur by construction. Assert both in simulation.
- Reset values:
  - cnt=W0, fifo_count=0, pointers=0.
  - `m_valid`=0, `frame_err`=0, `m_data`=0 (storage cleared).
  - `s_ready`=1 in the first cycle after reset.
- Reset in the middle of a block drops the partial block and all FIFO contents. Nothing is emitted for it.

## Timing
- Latency: W3 accepted at edge t → `m_valid`=1 and `m_data` valid after edge t (cycle t+1) when the FIFO was empty. This is one register stage.
- Throughput: one block per 4 cycles at full input rate. Input never stalls while the FIFO has space.
- `frame_err` asserts in the cycle after the offending beat for exactly one cycle. Back-to-back errors give back-to-back pulses.
- `m_data` holds stable while `m_valid && !m_ready`.

## Structure
- Shared package `aes_pkg`:
  - `STATE_W`=128 and `WORD_W`=32.
  - Functions `shiftrows_f` and `inv_shiftrows_f`, so the bench and RTL share one definition of the layout.
- One sub-module: `state_fifo`, a synchronous FIFO with parameters width and depth, a count output, and active-low synchronous reset.
- The top level holds the counter/FSM, the assembly register, framing checks, and the `s_ready` logic.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `s_valid`=1 → `m_valid`=0, `frame_err`=0, `s_ready`=1 on release, nothing emitted.
- Golden block: beats 03020100, 06050407, 09080b0a, 0c0f0e0d (`s_last` on beat 4), `m_ready`=1 → one cycle later `m_data`=0f0e0d0c_0b0a0908_07060504_03020100, `m_valid` high for 1 cycle.
- Backpressure: `m_ready`=0, stream 3 golden-style blocks:
  - Two blocks fill the FIFO.
  - Beats 1–3 of block 3 are accepted, then `s_ready`=0 at beat 4.
  - Raising `m_ready` drains the FIFO in order, and block 3 lands after the first pop.
- Early last: `s_last` on beat 2 → `frame_err` pulse for 1 cycle, no `m_valid`. The next 4 golden beats yield the golden result.
- Missing last: 4 beats with `s_last`=0 → `frame_err` pulse, no push, cnt back to W0.
- Round trip and reset mid-block:
  - 1000 random x, each sent as `shiftrows_f(x)` with random `s_valid`/`m_ready` gaps → every `m_data`==x.
  - One `rst_n` pulse after beat 2 drops that block, and subsequent blocks stay correct.
